// File: rtl/sram_1rw_masked_init_if.sv
// Request/response bundle for the 1RW masked memory: controller drives the access,
// the array returns registered read data, its valid strobe and init status.
interface sram_1rw_masked_init_if #(
  parameter int DATA_W = 2848,
  parameter int ADDR_W = 5,
  parameter int MASK_W = 8
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [DATA_W-1:0] RW0_wdata;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_rdata;
  logic              RW0_rvalid;
  logic              init_done;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wdata, RW0_wmask,
    input  RW0_rdata, RW0_rvalid, init_done
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wdata, RW0_wmask,
    output RW0_rdata, RW0_rvalid, init_done
  );
endinterface

// File: rtl/sram_1rw_masked_init.sv
// Parametrised 1RW lane-masked array with a zeroing sweep after reset, a registered
// read port with a one-cycle valid strobe, and read data that holds until the next read.
module sram_1rw_masked_init #(
  parameter int DATA_W        = 2848,
  parameter int DEPTH         = 32,
  parameter int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MASK_W        = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  sram_1rw_masked_init_if.slave rw
);
  localparam int LANE_W = DATA_W / MASK_W;

  typedef enum logic {INIT, READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              init_done_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic              sweep, acc, wr_acc, rd_acc, in_range;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0][LANE_W-1:0] rd_lane;

  // Requests are only honoured once the array is ready; nothing is queued.
  assign sweep    = (state_q == INIT) && !reset;
  assign acc      = rw.RW0_en && init_done_q && !reset;
  assign wr_acc   = acc && rw.RW0_wmode;
  assign rd_acc   = acc && !rw.RW0_wmode;
  assign in_range = 32'(rw.RW0_addr) < DEPTH;
  assign mem_addr = sweep ? ptr_q : rw.RW0_addr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = READY;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      if (INIT_ON_RESET != 0) state_q <= INIT;
      else                    state_q <= READY;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= (state_d == READY);
    end
  end

  // One storage array per mask lane so each lane carries its own write enable.
  for (genvar g = 0; g < MASK_W; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic              we;
    logic [LANE_W-1:0] wd;

    assign we = sweep || (wr_acc && in_range && rw.RW0_wmask[g]);
    assign wd = sweep ? '0 : rw.RW0_wdata[g*LANE_W +: LANE_W];

    always_ff @(posedge RW0_clk) begin
      if (we) mem[mem_addr] <= wd;
    end

    assign rd_lane[g] = in_range ? mem[rw.RW0_addr] : '0;
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_lane;
    end
  end

  assign rw.RW0_rdata  = rdata_q;
  assign rw.RW0_rvalid = rvalid_q;
  assign rw.init_done  = init_done_q;
endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Bench for sram_1rw_masked_init: a 32-deep full-width array and a 20-deep narrow array,
// each checked against a plain word-array model of the memory.
module tb_sram_1rw_masked_init;
  localparam int DW  = 2848;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int MW  = 8;
  localparam int LW  = DW / MW;
  localparam int DWB  = 64;
  localparam int DEPB = 20;
  localparam int LWB  = DWB / MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  sram_1rw_masked_init_if #(.DATA_W(DW),  .ADDR_W(AW), .MASK_W(MW)) bus_a ();
  sram_1rw_masked_init_if #(.DATA_W(DWB), .ADDR_W(AW), .MASK_W(MW)) bus_b ();

  sram_1rw_masked_init #(.DATA_W(DW), .DEPTH(DEP), .MASK_W(MW), .INIT_ON_RESET(1)) dut_a (
    .RW0_clk(clk), .reset(rst_a), .rw(bus_a.slave));
  sram_1rw_masked_init #(.DATA_W(DWB), .DEPTH(DEPB), .MASK_W(MW), .INIT_ON_RESET(1)) dut_b (
    .RW0_clk(clk), .reset(rst_b), .rw(bus_b.slave));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  ref_a [DEP];
  logic [DWB-1:0] ref_b [DEPB];

  function automatic logic [DW-1:0] merge_a(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW; b++) if (m[b / LW]) r[b] = wd[b];
    return r;
  endfunction

  function automatic logic [DWB-1:0] merge_b(input logic [DWB-1:0] old, input logic [DWB-1:0] wd,
                                             input logic [MW-1:0] m);
    logic [DWB-1:0] r;
    r = old;
    for (int b = 0; b < DWB; b++) if (m[b / LWB]) r[b] = wd[b];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_a();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] lo(input logic [DW-1:0] x);
    return x[63:0];
  endfunction

  function automatic int fdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < DW; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic drive_a(input logic en, input logic wm, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [MW-1:0] mk);
    @(negedge clk);
    bus_a.RW0_en = en; bus_a.RW0_wmode = wm; bus_a.RW0_addr = ad;
    bus_a.RW0_wdata = wd; bus_a.RW0_wmask = mk;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic en, input logic wm, input logic [AW-1:0] ad,
                         input logic [DWB-1:0] wd, input logic [MW-1:0] mk);
    @(negedge clk);
    bus_b.RW0_en = en; bus_b.RW0_wmode = wm; bus_b.RW0_addr = ad;
    bus_b.RW0_wdata = wd; bus_b.RW0_wmask = mk;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1; bus_a.RW0_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", bus_a.init_done); end
    checks++; if (bus_a.RW0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus_a.RW0_rvalid); end
    checks++; if (bus_a.RW0_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got low %h want 0", lo(bus_a.RW0_rdata)); end
    for (int c = 1; c <= DEP; c++) begin
      @(negedge clk);
      if (c == 1) rst_a = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus_a.init_done !== (c == DEP)) begin
        errors++; $display("FAIL sweep_init_done cycle %0d: got %b want %b", c, bus_a.init_done, c == DEP);
      end
    end
    for (int i = 0; i < DEP; i++) ref_a[i] = '0;
  endtask

  task automatic test_init_reads;
    for (int a = 0; a < DEP; a++) begin
      drive_a(1'b1, 1'b0, AW'(a), '0, '0);
      checks++; if (bus_a.RW0_rvalid !== 1'b1) begin errors++; $display("FAIL init_read_rvalid a=%0d: got %b want 1", a, bus_a.RW0_rvalid); end
      checks++; if (bus_a.RW0_rdata !== ref_a[a]) begin errors++; $display("FAIL init_read a=%0d: got low %h want low %h bit %0d", a, lo(bus_a.RW0_rdata), lo(ref_a[a]), fdiff(bus_a.RW0_rdata, ref_a[a])); end
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    checks++; if (bus_a.RW0_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b want 0", bus_a.RW0_rvalid); end
  endtask

  task automatic test_masked_write;
    logic [DW-1:0] exp, d;
    exp = '0;
    exp[0 +: LW]    = {LW{1'b1}};
    exp[7*LW +: LW] = {LW{1'b1}};
    drive_a(1'b1, 1'b1, 5'd5, {DW{1'b1}}, 8'h81);
    ref_a[5] = merge_a(ref_a[5], {DW{1'b1}}, 8'h81);
    checks++; if (bus_a.RW0_rvalid !== 1'b0) begin errors++; $display("FAIL write_rvalid: got %b want 0", bus_a.RW0_rvalid); end
    drive_a(1'b1, 1'b0, 5'd5, '0, '0);
    checks++; if (bus_a.RW0_rdata !== exp) begin errors++; $display("FAIL mask81_read: got low %h want low %h bit %0d", lo(bus_a.RW0_rdata), lo(exp), fdiff(bus_a.RW0_rdata, exp)); end
    d = rnd_a();
    drive_a(1'b1, 1'b1, 5'd5, d, 8'h00);
    drive_a(1'b1, 1'b0, 5'd5, '0, '0);
    checks++; if (bus_a.RW0_rdata !== exp) begin errors++; $display("FAIL mask0_noop: got low %h want low %h bit %0d", lo(bus_a.RW0_rdata), lo(exp), fdiff(bus_a.RW0_rdata, exp)); end
  endtask

  task automatic test_hold;
    logic [DW-1:0] va, vb;
    int highs;
    va = rnd_a(); vb = rnd_a(); highs = 0;
    drive_a(1'b1, 1'b1, 5'd3, va, 8'hFF);
    drive_a(1'b1, 1'b0, 5'd3, '0, '0);
    if (bus_a.RW0_rvalid === 1'b1) highs++;
    checks++; if (bus_a.RW0_rdata !== va) begin errors++; $display("FAIL hold_read: got low %h want low %h", lo(bus_a.RW0_rdata), lo(va)); end
    drive_a(1'b1, 1'b1, 5'd3, vb, 8'hFF);
    ref_a[3] = vb;
    if (bus_a.RW0_rvalid === 1'b1) highs++;
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b0, 1'b0, '0, '0, '0);
      if (bus_a.RW0_rvalid === 1'b1) highs++;
      checks++; if (bus_a.RW0_rdata !== va) begin errors++; $display("FAIL hold_idle %0d: got low %h want low %h", i, lo(bus_a.RW0_rdata), lo(va)); end
    end
    checks++; if (highs != 1) begin errors++; $display("FAIL hold_rvalid_count: got %0d want 1", highs); end
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < 3; a++) begin
      ref_a[a] = rnd_a();
      drive_a(1'b1, 1'b1, AW'(a), ref_a[a], 8'hFF);
    end
    for (int a = 0; a < 3; a++) begin
      drive_a(1'b1, 1'b0, AW'(a), '0, '0);
      checks++; if (bus_a.RW0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid %0d: got %b want 1", a, bus_a.RW0_rvalid); end
      checks++; if (bus_a.RW0_rdata !== ref_a[a]) begin errors++; $display("FAIL b2b_data %0d: got low %h want low %h", a, lo(bus_a.RW0_rdata), lo(ref_a[a])); end
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    checks++; if (bus_a.RW0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_rvalid: got %b want 0", bus_a.RW0_rvalid); end
  endtask

  task automatic test_random;
    logic [DW-1:0] exp_rd, d;
    logic [MW-1:0] m;
    logic [AW-1:0] ad;
    int op;
    drive_a(1'b1, 1'b0, 5'd7, '0, '0);
    exp_rd = ref_a[7];
    checks++; if (bus_a.RW0_rdata !== exp_rd) begin errors++; $display("FAIL rand_first: got low %h want low %h", lo(bus_a.RW0_rdata), lo(exp_rd)); end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 2);
      ad = AW'($urandom_range(0, DEP - 1));
      d  = rnd_a();
      m  = MW'($urandom);
      if (op == 0) drive_a(1'b0, 1'b0, ad, d, m);
      else if (op == 1) begin
        drive_a(1'b1, 1'b1, ad, d, m);
        ref_a[ad] = merge_a(ref_a[ad], d, m);
      end else begin
        exp_rd = ref_a[ad];
        drive_a(1'b1, 1'b0, ad, d, m);
      end
      checks++; if (bus_a.RW0_rvalid !== (op == 2)) begin errors++; $display("FAIL rand_rvalid %0d: got %b want %b", i, bus_a.RW0_rvalid, op == 2); end
      checks++; if (bus_a.RW0_rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata %0d: got low %h want low %h bit %0d", i, lo(bus_a.RW0_rdata), lo(exp_rd), fdiff(bus_a.RW0_rdata, exp_rd)); end
    end
  endtask

  task automatic test_reset_mid_sweep;
    @(negedge clk);
    rst_a = 1'b1; bus_a.RW0_en = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) rst_a = 1'b0;
      bus_a.RW0_en = (c == 5) || (c == 8); bus_a.RW0_wmode = (c == 5);
      bus_a.RW0_addr = 5'd2; bus_a.RW0_wdata = {DW{1'b1}}; bus_a.RW0_wmask = 8'hFF;
      @(posedge clk); #1;
      if (c == 8) begin
        checks++; if (bus_a.RW0_rvalid !== 1'b0) begin errors++; $display("FAIL sweep_read_rvalid: got %b want 0", bus_a.RW0_rvalid); end
      end
    end
    @(negedge clk);
    rst_a = 1'b1; bus_a.RW0_en = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= DEP; c++) begin
      @(negedge clk);
      if (c == 1) rst_a = 1'b0;
      bus_a.RW0_en = (c == 10); bus_a.RW0_wmode = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_a.init_done !== (c == DEP)) begin
        errors++; $display("FAIL resweep_init_done cycle %0d: got %b want %b", c, bus_a.init_done, c == DEP);
      end
    end
    for (int i = 0; i < DEP; i++) ref_a[i] = '0;
    drive_a(1'b1, 1'b0, 5'd2, '0, '0);
    checks++; if (bus_a.RW0_rdata !== ref_a[2]) begin errors++; $display("FAIL sweep_write_ignored: got low %h want 0", lo(bus_a.RW0_rdata)); end
    drive_a(1'b1, 1'b0, 5'd31, '0, '0);
    checks++; if (bus_a.RW0_rdata !== ref_a[31]) begin errors++; $display("FAIL resweep_zero31: got low %h want 0", lo(bus_a.RW0_rdata)); end
  endtask

  task automatic test_out_of_range;
    logic [DWB-1:0] d;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    for (int c = 1; c <= DEPB; c++) begin
      @(negedge clk);
      if (c == 1) rst_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus_b.init_done !== (c == DEPB)) begin
        errors++; $display("FAIL b_init_done cycle %0d: got %b want %b", c, bus_b.init_done, c == DEPB);
      end
    end
    for (int i = 0; i < DEPB; i++) ref_b[i] = '0;
    d = {$urandom, $urandom};
    drive_b(1'b1, 1'b1, 5'd5, d, 8'hFF);
    ref_b[5] = merge_b(ref_b[5], d, 8'hFF);
    d = {$urandom, $urandom};
    drive_b(1'b1, 1'b1, 5'd19, d, 8'h3C);
    ref_b[19] = merge_b(ref_b[19], d, 8'h3C);
    drive_b(1'b1, 1'b0, 5'd25, '0, '0);
    checks++; if (bus_b.RW0_rvalid !== 1'b1) begin errors++; $display("FAIL oor_rvalid: got %b want 1", bus_b.RW0_rvalid); end
    checks++; if (bus_b.RW0_rdata !== '0) begin errors++; $display("FAIL oor_rdata: got %h want 0", bus_b.RW0_rdata); end
    drive_b(1'b1, 1'b1, 5'd25, {DWB{1'b1}}, 8'hFF);
    drive_b(1'b1, 1'b0, 5'd5, '0, '0);
    checks++; if (bus_b.RW0_rdata !== ref_b[5]) begin errors++; $display("FAIL oor_alias5: got %h want %h", bus_b.RW0_rdata, ref_b[5]); end
    drive_b(1'b1, 1'b0, 5'd19, '0, '0);
    checks++; if (bus_b.RW0_rdata !== ref_b[19]) begin errors++; $display("FAIL last_word19: got %h want %h", bus_b.RW0_rdata, ref_b[19]); end
    drive_b(1'b1, 1'b0, 5'd20, '0, '0);
    checks++; if (bus_b.RW0_rvalid !== 1'b1 || bus_b.RW0_rdata !== '0) begin errors++; $display("FAIL oor20: got %b/%h want 1/0", bus_b.RW0_rvalid, bus_b.RW0_rdata); end
    drive_b(1'b1, 1'b0, 5'd31, '0, '0);
    checks++; if (bus_b.RW0_rdata !== '0) begin errors++; $display("FAIL oor31: got %h want 0", bus_b.RW0_rdata); end
  endtask

  initial begin
    bus_a.RW0_en = 1'b0; bus_a.RW0_wmode = 1'b0; bus_a.RW0_addr = '0;
    bus_a.RW0_wdata = '0; bus_a.RW0_wmask = '0;
    bus_b.RW0_en = 1'b0; bus_b.RW0_wmode = 1'b0; bus_b.RW0_addr = '0;
    bus_b.RW0_wdata = '0; bus_b.RW0_wmask = '0;
    test_reset;
    test_init_reads;
    test_masked_write;
    test_hold;
    test_back_to_back;
    test_random;
    test_reset_mid_sweep;
    test_out_of_range;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
